mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath; sits beside the ALU, downstream of the ALU operand selection.
- Consumes the A-register operand and the selected B operand.
- Executes MULT/MULTU/DIV/DIVU over 32 iteration cycles and holds results in internal Hi/Lo registers, which mfhi/mflo read.
- Control unit starts an operation with a one-cycle pulse and waits on Busy/Done.

Parameters:
- WIDTH, 32, operand and Hi/Lo width.
- ITERS, WIDTH, iteration count per operation.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- OpA  input  WIDTH  multiplicand / dividend (A register).
- OpB  input  WIDTH  multiplier / divisor (selected B operand).
- MultStart  input  1  start-multiply pulse.
- DivStart  input  1  start-divide pulse.
- SignedOp  input  1  1 = MULT/DIV (two's complement), 0 = MULTU/DIVU; sampled with start.
- Hi  output  WIDTH  product upper word / remainder.
- Lo  output  WIDTH  product lower word / quotient.
- Busy  output  1  high while iterating.
- Done  output  1  one-cycle completion pulse.
- DivZero  output  1  last accepted divide had OpB == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - State is IDLE.
  - Hi, Lo, internal accumulators and counter are 0.
  - Busy, Done and DivZero are 0.
  - This applies mid-operation too: the in-flight operation is discarded and no Done is produced.
- States:
  - IDLE: accept a start.
  - MULT, DIV: iterate.
  - DONE: one cycle, then return to IDLE.
- Start acceptance:
  - Starts are sampled only in IDLE; starts in any other state are ignored.
  - If MultStart and DivStart are both high, MultStart wins.
  - OpA, OpB and SignedOp are latched at the accepting edge; later changes on the inputs have no effect.
  - DivZero clears at every accepting edge, then is set again only by a divide-by-zero.
- Sign conditioning:
  - With SignedOp = 1, operate on magnitudes |OpA| and |OpB|; the magnitude of 0x80000000 is 2^31 unsigned.
  - Record negProd/negQuot = sign(OpA) XOR sign(OpB), and negRem = sign(OpA).
- MULT:
  - Shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
  - Counter runs 0..ITERS-1.
  - On the final iteration edge, go to DONE and write {Hi,Lo} = product, two's-complement negated if negProd.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - On the final edge, go to DONE and write Lo = quotient (negated if negQuot) and Hi = remainder (negated if negRem).
  - 0x80000000 / 0xFFFFFFFF signed gives Lo = 0x80000000, Hi = 0. No overflow flag.
- Divide by zero:
  - OpB == 0 at acceptance: go directly to DONE on the next edge.
  - Set DivZero; Hi and Lo are left unchanged.
- Timing:
  - Start accepted at edge k.
  - Busy = 1 from after edge k until edge k+ITERS.
  - Hi/Lo update at edge k+ITERS.
  - Done = 1 for exactly the cycle after edge k+ITERS; back in IDLE after edge k+ITERS+1.
  - A new start is accepted no earlier than edge k+ITERS+1.
  - Divide-by-zero case: Done is high during the cycle after edge k+1.
- Outputs:
  - Hi and Lo are registered and hold their value between completed operations.
  - Busy and Done are decoded from state and are never both high.

Decomposition:
- Package mdu_pkg:
  - state encoding (S_IDLE, S_MULT, S_DIV, S_DONE);
  - MDU_WIDTH = 32;
  - counter width = $clog2(ITERS).
- One combinational sub-module, mdu_sign_fix:
  - conditional two's-complement negate (magnitude in, neg flag in, WIDTH out);
  - instantiated for operand magnitudes and result correction.

Test Plan:
- MULT signed, OpA=7, OpB=0xFFFFFFFD (-3) -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done exactly 32 edges after the start edge; Busy high for 32 cycles.
- MULTU, OpA=OpB=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV signed:
  - OpA=0xFFFFFFF9 (-7), OpB=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - Then OpA=0x80000000, OpB=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Divide by zero:
  - Preload Hi=0x11, Lo=0x22; DIVU with OpA=100, OpB=0 -> Done one cycle after the start edge, DivZero=1, Hi/Lo unchanged.
  - Next MULT start -> DivZero clears at acceptance.
- Start filtering:
  - MultStart pulsed at iteration 5 of an active DIV -> ignored, DIV result correct.
  - Simultaneous MultStart and DivStart in IDLE -> multiply executes.
- Reset mid-operation:
  - reset low asynchronously at iteration 10 of a MULT -> Hi=Lo=0, Busy=Done=0 immediately, with no Done later.
  - After reset is released, a fresh MULTU 3*5 -> Lo=15, Hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mag,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? ((~mag) + WIDTH'(1)) : mag;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with Hi/Lo result registers.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             MultStart,
    input  logic             DivStart,
    input  logic             SignedOp,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opr;
    logic               neg_res;
    logic               neg_rem;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     psum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
        .mag (OpA),
        .neg (SignedOp & OpA[WIDTH-1]),
        .res (mag_a)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
        .mag (OpB),
        .neg (SignedOp & OpB[WIDTH-1]),
        .res (mag_b)
    );

    // acc holds {partial product, remaining multiplier bits} for MULT and
    // {partial remainder, remaining dividend / quotient bits} for DIV.
    always_comb begin
        psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opr} : '0);
        mul_next = {psum, acc[WIDTH-1:1]};
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opr};
        div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_prod_fix (
        .mag (mul_next),
        .neg (neg_res),
        .res (prod_fix)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_quot_fix (
        .mag (div_next[WIDTH-1:0]),
        .neg (neg_res),
        .res (quot_fix)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
        .mag (div_next[2*WIDTH-1:WIDTH]),
        .neg (neg_rem),
        .res (rem_fix)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opr     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MultStart || DivStart) begin
                        DivZero <= 1'b0;
                        cnt     <= '0;
                        neg_res <= SignedOp & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        neg_rem <= SignedOp & OpA[WIDTH-1];
                        if (MultStart) begin
                            state <= S_MULT;
                            opr   <= mag_a;
                            acc   <= {{WIDTH{1'b0}}, mag_b};
                        end else begin
                            state <= S_DIV;
                            opr   <= mag_b;
                            acc   <= {{WIDTH{1'b0}}, mag_a};
                        end
                    end
                end
                S_MULT: begin
                    acc <= mul_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state    <= S_DONE;
                        {Hi, Lo} <= prod_fix;
                    end
                end
                S_DIV: begin
                    if (opr == '0) begin
                        state   <= S_DONE;
                        DivZero <= 1'b1;
                    end else begin
                        acc <= div_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state <= S_DONE;
                            Hi    <= rem_fix;
                            Lo    <= quot_fix;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Busy = (state == S_MULT) || (state == S_DIV);
    assign Done = (state == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected Hi/Lo/DivZero/latency queued at issue, checked on Done.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        MultStart;
    logic        DivStart;
    logic        SignedOp;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_err;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .OpA       (OpA),
        .OpB       (OpB),
        .MultStart (MultStart),
        .DivStart  (DivStart),
        .SignedOp  (SignedOp),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result computed with 64-bit arithmetic, independent of the iterative datapath.
    task automatic push_expect(input logic ms, input logic sg, input logic [31:0] a, input logic [31:0] b);
        exp_t          e;
        longint        sp, sa, sbv, q, r;
        longint unsigned up, ua, ub;
        logic [63:0]   p64;
        e.dz  = 1'b0;
        e.lat = 32;
        if (ms) begin
            if (sg) begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                p64 = sp;
            end else begin
                ua  = {32'b0, a};
                ub  = {32'b0, b};
                up  = ua * ub;
                p64 = up;
            end
            model_hi = p64[63:32];
            model_lo = p64[31:0];
        end else if (b == 32'b0) begin
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            if (sg) begin
                sa  = longint'($signed(a));
                sbv = longint'($signed(b));
            end else begin
                sa  = longint'({32'b0, a});
                sbv = longint'({32'b0, b});
            end
            q = sa / sbv;
            r = sa % sbv;
            model_lo = q[31:0];
            model_hi = r[31:0];
        end
        e.hi = model_hi;
        e.lo = model_lo;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic ms, input logic ds, input logic sg,
                          input logic [31:0] a, input logic [31:0] b, input int inject);
        exp_t e;
        int   n;
        int   busy_cnt;
        logic seen;
        push_expect(ms, sg, a, b);
        @(negedge clk);
        OpA       = a;
        OpB       = b;
        SignedOp  = sg;
        MultStart = ms;
        DivStart  = ds;
        @(posedge clk);
        #1;
        MultStart = 1'b0;
        DivStart  = 1'b0;
        OpA       = $urandom;
        OpB       = $urandom;
        SignedOp  = ~sg;
        chk("dz_clear_at_accept", {63'b0, DivZero}, 64'd0);
        busy_cnt = Busy ? 1 : 0;
        seen     = 1'b0;
        n        = 0;
        while (n < 100 && !seen) begin
            @(posedge clk);
            n++;
            #1;
            if (Done) begin
                seen = 1'b1;
            end else begin
                if (Busy) busy_cnt++;
                if (n == inject) begin
                    MultStart = 1'b1;
                    OpA       = 32'hDEAD_BEEF;
                end
                if (n == inject + 1) MultStart = 1'b0;
            end
        end
        MultStart = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("latency", 64'(n), 64'(e.lat));
            chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
            chk("busy_with_done", {63'b0, Busy}, 64'd0);
            chk("hi", {32'b0, Hi}, {32'b0, e.hi});
            chk("lo", {32'b0, Lo}, {32'b0, e.lo});
            chk("divzero", {63'b0, DivZero}, {63'b0, e.dz});
            @(posedge clk);
            #1;
            chk("done_one_cycle", {63'b0, Done}, 64'd0);
            chk("idle_not_busy", {63'b0, Busy}, 64'd0);
        end
    endtask

    initial begin
        int   dn;
        logic ms;
        n_cmp     = 0;
        n_err     = 0;
        model_hi  = '0;
        model_lo  = '0;
        reset     = 1'b0;
        OpA       = '0;
        OpB       = '0;
        MultStart = 1'b0;
        DivStart  = 1'b0;
        SignedOp  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", {32'b0, Hi}, 64'd0);
        chk("rst_lo", {32'b0, Lo}, 64'd0);
        chk("rst_busy", {63'b0, Busy}, 64'd0);
        chk("rst_done", {63'b0, Done}, 64'd0);
        chk("rst_dz", {63'b0, DivZero}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(1, 0, 1, 32'd7, 32'hFFFF_FFFD, -1);
        chk("mult_s_hi", {32'b0, Hi}, 64'hFFFF_FFFF);
        chk("mult_s_lo", {32'b0, Lo}, 64'hFFFF_FFEB);
        run_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("multu_hi", {32'b0, Hi}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'b0, Lo}, 64'h0000_0001);
        run_op(0, 1, 1, 32'hFFFF_FFF9, 32'd2, -1);
        chk("div_s_lo", {32'b0, Lo}, 64'hFFFF_FFFD);
        chk("div_s_hi", {32'b0, Hi}, 64'hFFFF_FFFF);
        run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("div_min_lo", {32'b0, Lo}, 64'h8000_0000);
        chk("div_min_hi", {32'b0, Hi}, 64'd0);

        run_op(0, 1, 0, 32'h0000_2211, 32'h0000_0100, -1);
        chk("preload_hi", {32'b0, Hi}, 64'h11);
        chk("preload_lo", {32'b0, Lo}, 64'h22);
        run_op(0, 1, 0, 32'd100, 32'd0, -1);
        chk("dz_hi_kept", {32'b0, Hi}, 64'h11);
        chk("dz_lo_kept", {32'b0, Lo}, 64'h22);
        run_op(1, 0, 1, 32'hFFFF_FFFB, 32'd6, -1);

        run_op(0, 1, 0, 32'd1000, 32'd7, 5);
        run_op(1, 1, 1, 32'hFFFF_FFF7, 32'd9, -1);

        for (int i = 0; i < 6; i++) begin
            ms = (i % 2) == 0;
            run_op(ms, ~ms, logic'($urandom_range(0, 1)), $urandom, $urandom, -1);
        end

        @(negedge clk);
        OpA       = 32'h1234_5678;
        OpB       = 32'h0000_0F0F;
        SignedOp  = 1'b0;
        MultStart = 1'b1;
        @(posedge clk);
        #1;
        MultStart = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("amid_rst_hi", {32'b0, Hi}, 64'd0);
        chk("amid_rst_lo", {32'b0, Lo}, 64'd0);
        chk("amid_rst_busy", {63'b0, Busy}, 64'd0);
        chk("amid_rst_done", {63'b0, Done}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) dn++;
        end
        chk("no_done_after_rst", 64'(dn), 64'd0);

        run_op(1, 0, 0, 32'd3, 32'd5, -1);
        chk("post_rst_lo", {32'b0, Lo}, 64'd15);
        chk("post_rst_hi", {32'b0, Hi}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
